// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data cache memory arbiter.
package mem_arbiter_pkg;

    // Arbiter control states: waiting for a request, moving a line, reporting completion.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_DONE  = 2'd2
    } mem_arb_state_e;

    // Requester indices on the two-bit request/grant vectors.
    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

    // Turns a requester index into its one-hot position on a two-bit vector.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// requester named by the priority bit.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_prio,
    output logic [1:0] o_gnt,
    output logic       o_winner
);

    // Resolve the winner; with no request the grant stays empty and the index is don't-care.
    always_comb begin
        o_gnt    = 2'b00;
        o_winner = REQ_ICACHE;
        case (i_req)
            2'b01: begin
                o_winner = REQ_ICACHE;
                o_gnt    = onehot2(REQ_ICACHE);
            end
            2'b10: begin
                o_winner = REQ_DCACHE;
                o_gnt    = onehot2(REQ_DCACHE);
            end
            2'b11: begin
                o_winner = i_prio;
                o_gnt    = onehot2(i_prio);
            end
            default: begin
                o_gnt    = 2'b00;
                o_winner = REQ_ICACHE;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between the I-cache and D-cache miss
// handlers, moving one cache line per grant as a burst of word transfers.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_i,
    input  logic [1:0]            we_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic [1:0]            gnt_o,
    output logic [1:0]            rvalid_o,
    output logic [1:0]            wready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            done_o,
    output logic                  busy_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int BYTES         = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT    = $clog2(BYTES);
    localparam int CNT_W         = $clog2(LINE_WORDS);
    localparam int LINE_OFF_BITS = $clog2(LINE_WORDS * BYTES);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << LINE_OFF_BITS) - ADDR_WIDTH'(1));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

    mem_arb_state_e        r_state;
    mem_arb_state_e        w_nextState;
    logic                  r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_prio;

    logic [1:0]            w_arbGnt;
    logic                  w_arbWinner;
    logic [ADDR_WIDTH-1:0] w_winnerAddr;
    logic [ADDR_WIDTH-1:0] w_memAddr;
    logic [DATA_WIDTH-1:0] w_ownerWdata;
    logic                  w_lastWord;

    rr_arb2 u_rrArb (
        .i_req    (req_i),
        .i_prio   (r_prio),
        .o_gnt    (w_arbGnt),
        .o_winner (w_arbWinner)
    );

    // Pick the line address of whoever wins this cycle and the write word of the current owner.
    always_comb begin
        w_winnerAddr = (w_arbWinner == REQ_DCACHE) ? addr1_i : addr0_i;
        w_ownerWdata = (r_owner == REQ_DCACHE) ? wdata1_i : wdata0_i;
    end

    // Word address walks up from the aligned line base; the sum wraps at the top of the address space.
    always_comb begin
        w_memAddr  = r_base + (ADDR_WIDTH'(r_cnt) << BYTE_SHIFT);
        w_lastWord = mem_ack_i && (r_cnt == CNT_LAST);
    end

    // State register; reset drops straight to IDLE, which abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: grant from IDLE, leave BURST on the last acknowledged word, DONE lasts one cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (|w_arbGnt) begin
                    w_nextState = ARB_BURST;
                end
            end
            ARB_BURST: begin
                if (w_lastWord) begin
                    w_nextState = ARB_DONE;
                end
            end
            ARB_DONE: begin
                w_nextState = ARB_IDLE;
            end
            default: begin
                w_nextState = ARB_IDLE;
            end
        endcase
    end

    // Burst bookkeeping: capture the winner's request at grant, count acknowledged words, hand priority over at the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= REQ_ICACHE;
            r_we    <= 1'b0;
            r_base  <= '0;
            r_cnt   <= '0;
            r_prio  <= REQ_ICACHE;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (|w_arbGnt) begin
                        r_owner <= w_arbWinner;
                        r_we    <= we_i[w_arbWinner];
                        r_base  <= w_winnerAddr & LINE_MASK;
                        r_cnt   <= '0;
                    end
                end
                ARB_BURST: begin
                    if (mem_ack_i) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ARB_DONE: begin
                    r_prio <= ~r_owner;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Output decode; the grant is also masked by reset so nothing leaks out while reset is held.
    always_comb begin
        gnt_o       = 2'b00;
        rvalid_o    = 2'b00;
        wready_o    = 2'b00;
        rdata_o     = '0;
        done_o      = 2'b00;
        busy_o      = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (r_state)
            ARB_IDLE: begin
                if (rst_n) begin
                    gnt_o = w_arbGnt;
                end
            end
            ARB_BURST: begin
                busy_o      = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = r_we;
                mem_addr_o  = w_memAddr;
                mem_wdata_o = w_ownerWdata;
                if (mem_ack_i) begin
                    if (r_we) begin
                        wready_o = onehot2(r_owner);
                    end else begin
                        rvalid_o = onehot2(r_owner);
                        rdata_o  = mem_rdata_i;
                    end
                end
            end
            ARB_DONE: begin
                busy_o = 1'b1;
                done_o = onehot2(r_owner);
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

endmodule
